// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one shift-add-3 binary-to-BCD engine between the
// frequency and duty channels. Define BCD_SAT_EN to saturate out-of-range frequencies.
module bcd_conv_sched #(
    parameter int FREQ_W      = 28,
    parameter int FREQ_DIGITS = 8,
    parameter int DUTY_W      = 7,
    parameter int DUTY_DIGITS = 3
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     freq_req,
    input  logic [FREQ_W-1:0]        freq_bin,
    output logic                     freq_ack,
    input  logic                     duty_req,
    input  logic [DUTY_W-1:0]        duty_bin,
    output logic                     duty_ack,
    output logic [4*FREQ_DIGITS-1:0] freq_bcd,
    output logic                     freq_vld,
    output logic                     freq_ovf,
    output logic [4*DUTY_DIGITS-1:0] duty_bcd,
    output logic                     duty_vld,
    output logic                     busy
);
    localparam int   BCD_DIG = FREQ_DIGITS + 1;
    localparam int   BCD_W   = 4 * BCD_DIG;
    localparam int   SH_W    = BCD_W + FREQ_W;
    localparam int   CNT_W   = $clog2(FREQ_W + 1);
    localparam logic CH_FREQ = 1'b0;
    localparam logic CH_DUTY = 1'b1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [SH_W-1:0]  sh, sh_step;
    logic [BCD_W-1:0] bcd_adj, bcd_new;
    logic [CNT_W-1:0] cnt, cnt_last;
    logic             chan, ptr;
    logic             grant_freq, grant_duty, last_shift;
    logic             spare_unused;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef BCD_SAT_EN
    function automatic logic [4*FREQ_DIGITS-1:0] freq_sat(input logic [BCD_W-1:0] b);
        if (b[BCD_W-1 -: 4] != 4'd0) return {FREQ_DIGITS{4'h9}};
        return b[4*FREQ_DIGITS-1:0];
    endfunction
`endif

    // Acks are masked while reset is asserted so no handshake can appear during reset.
    assign grant_freq = rst && freq_req && (!duty_req || ptr == CH_FREQ);
    assign grant_duty = rst && duty_req && (!freq_req || ptr == CH_DUTY);

    assign cnt_last   = (chan == CH_DUTY) ? CNT_W'(DUTY_W - 1) : CNT_W'(FREQ_W - 1);
    assign last_shift = (cnt == cnt_last);

    // {BCD field, binary field}; one add-3 pass then one left shift per clock.
    assign bcd_adj = add3(sh[SH_W-1 -: BCD_W]);
    assign sh_step = {bcd_adj[BCD_W-2:0], sh[FREQ_W-1:0], 1'b0};
    assign bcd_new = sh_step[SH_W-1 -: BCD_W];

    assign busy     = (state != IDLE);
    assign freq_vld = (state == DONE) && (chan == CH_FREQ);
    assign duty_vld = (state == DONE) && (chan == CH_DUTY);

`ifdef BCD_SAT_EN
    assign spare_unused = bcd_adj[BCD_W-1];
`else
    assign spare_unused = bcd_adj[BCD_W-1] ^ (|bcd_new[BCD_W-1 -: 4]);
    assign freq_ovf     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        freq_ack  = 1'b0;
        duty_ack  = 1'b0;
        case (state)
            IDLE: begin
                freq_ack = grant_freq;
                duty_ack = grant_duty;
                if (grant_freq || grant_duty) state_nxt = SHIFT;
            end
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            chan     <= CH_FREQ;
            ptr      <= CH_FREQ;
            freq_bcd <= '0;
            duty_bcd <= '0;
`ifdef BCD_SAT_EN
            freq_ovf <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_freq || grant_duty) begin
                        chan <= grant_duty ? CH_DUTY : CH_FREQ;
                        // Duty operand sits at the top of the binary field so it needs only DUTY_W shifts.
                        sh   <= grant_duty ? {{BCD_W{1'b0}}, duty_bin, {(FREQ_W-DUTY_W){1'b0}}}
                                           : {{BCD_W{1'b0}}, freq_bin};
                        cnt  <= '0;
                        if (freq_req && duty_req) ptr <= ~ptr;
                    end
                end
                SHIFT: begin
                    sh  <= sh_step;
                    cnt <= cnt + 1'b1;
                    if (last_shift) begin
                        if (chan == CH_FREQ) begin
`ifdef BCD_SAT_EN
                            freq_bcd <= freq_sat(bcd_new);
                            freq_ovf <= |bcd_new[BCD_W-1 -: 4];
`else
                            freq_bcd <= bcd_new[4*FREQ_DIGITS-1:0];
`endif
                        end else begin
                            duty_bcd <= bcd_new[4*DUTY_DIGITS-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: vector table, arbitration/reset sequences and
// randomized conversions checked against a decimal-arithmetic reference model.
module tb_bcd_conv_sched;
    localparam int FREQ_W      = 28;
    localparam int FREQ_DIGITS = 8;
    localparam int DUTY_W      = 7;
    localparam int DUTY_DIGITS = 3;

    logic                     clk_50M = 1'b0;
    logic                     rst = 1'b0;
    logic                     freq_req = 1'b0;
    logic [FREQ_W-1:0]        freq_bin = '0;
    logic                     freq_ack;
    logic                     duty_req = 1'b0;
    logic [DUTY_W-1:0]        duty_bin = '0;
    logic                     duty_ack;
    logic [4*FREQ_DIGITS-1:0] freq_bcd;
    logic                     freq_vld;
    logic                     freq_ovf;
    logic [4*DUTY_DIGITS-1:0] duty_bcd;
    logic                     duty_vld;
    logic                     busy;

    int checks = 0;
    int failures = 0;

    bcd_conv_sched #(
        .FREQ_W(FREQ_W), .FREQ_DIGITS(FREQ_DIGITS), .DUTY_W(DUTY_W), .DUTY_DIGITS(DUTY_DIGITS)
    ) dut (
        .clk_50M(clk_50M), .rst(rst),
        .freq_req(freq_req), .freq_bin(freq_bin), .freq_ack(freq_ack),
        .duty_req(duty_req), .duty_bin(duty_bin), .duty_ack(duty_ack),
        .freq_bcd(freq_bcd), .freq_vld(freq_vld), .freq_ovf(freq_ovf),
        .duty_bcd(duty_bcd), .duty_vld(duty_vld), .busy(busy)
    );

    initial forever #10 clk_50M = ~clk_50M;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ch;
        logic [27:0] val;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] to_bcd(input longint unsigned v);
        logic [35:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 9; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Returns {ovf, freq_bcd} expected for a frequency operand.
    function automatic logic [32:0] model_freq(input longint unsigned v);
        logic [35:0] d;
`ifdef BCD_SAT_EN
        if (v > 64'd99999999) return {1'b1, 32'h99999999};
        d = to_bcd(v);
`else
        d = to_bcd(v % 64'd100000000);
`endif
        return {1'b0, d[31:0]};
    endfunction

    task automatic start(input logic ch, input logic [27:0] val);
        @(negedge clk_50M);
        if (ch) begin
            duty_bin = val[6:0];
            duty_req = 1'b1;
        end else begin
            freq_bin = val;
            freq_req = 1'b1;
        end
        #1;
        chk(ch ? "duty_ack_grant" : "freq_ack_grant", ch ? duty_ack : freq_ack, 1'b1);
        @(posedge clk_50M);
    endtask

    // Called just after the transfer edge; checks every cycle through the return to IDLE.
    task automatic conv_tail(input logic ch, input logic [31:0] exp_bcd, input logic exp_ovf);
        int          w;
        logic [31:0] f_hold;
        logic [11:0] d_hold;
        logic        o_hold;
        w      = ch ? DUTY_W : FREQ_W;
        f_hold = freq_bcd;
        d_hold = duty_bcd;
        o_hold = freq_ovf;
        for (int k = 1; k <= w + 1; k++) begin
            @(negedge clk_50M);
            if (k == 1) begin
                if (ch) duty_req = 1'b0;
                else    freq_req = 1'b0;
            end
            chk("busy_during_conv", busy, 1'b1);
            chk("ack_outside_idle", {freq_ack, duty_ack}, 2'b00);
            chk(ch ? "duty_vld_timing" : "freq_vld_timing", ch ? duty_vld : freq_vld, (k == w + 1));
            chk(ch ? "freq_vld_other" : "duty_vld_other", ch ? freq_vld : duty_vld, 1'b0);
        end
        if (ch) begin
            chk("duty_bcd", duty_bcd, exp_bcd[11:0]);
            chk("freq_bcd_untouched", freq_bcd, f_hold);
            chk("freq_ovf_untouched", freq_ovf, o_hold);
        end else begin
            chk("freq_bcd", freq_bcd, exp_bcd);
            chk("freq_ovf", freq_ovf, exp_ovf);
            chk("duty_bcd_untouched", duty_bcd, d_hold);
        end
        @(negedge clk_50M);
        chk("busy_after_done", busy, 1'b0);
        chk("vld_after_done", {freq_vld, duty_vld}, 2'b00);
        chk(ch ? "duty_bcd_hold" : "freq_bcd_hold", ch ? duty_bcd : freq_bcd,
            ch ? {20'd0, exp_bcd[11:0]} : exp_bcd);
    endtask

    task automatic run(input logic ch, input logic [27:0] val, input logic [31:0] exp_bcd,
                       input logic exp_ovf);
        start(ch, val);
        conv_tail(ch, exp_bcd, exp_ovf);
    endtask

    initial begin
        logic [32:0] m;
        logic        ch;
        logic [27:0] v;
        int          vld_seen;

        vecs[0] = '{1'b0, 28'd12345678, 32'h12345678, 1'b0};
        vecs[1] = '{1'b1, 28'd100,      32'h00000100, 1'b0};
        vecs[2] = '{1'b1, 28'd0,        32'h00000000, 1'b0};
`ifdef BCD_SAT_EN
        vecs[3] = '{1'b0, 28'd268435455, 32'h99999999, 1'b1};
        vecs[7] = '{1'b0, 28'd100000000, 32'h99999999, 1'b1};
`else
        vecs[3] = '{1'b0, 28'd268435455, 32'h68435455, 1'b0};
        vecs[7] = '{1'b0, 28'd100000000, 32'h00000000, 1'b0};
`endif
        vecs[4] = '{1'b0, 28'd99999999, 32'h99999999, 1'b0};
        vecs[5] = '{1'b0, 28'd0,        32'h00000000, 1'b0};
        vecs[6] = '{1'b1, 28'd127,      32'h00000127, 1'b0};

        // Reset held: everything zero, and a request cannot be acked.
        repeat (3) @(negedge clk_50M);
        freq_req = 1'b1;
        #1;
        chk("reset_outputs", {freq_bcd, duty_bcd, freq_ovf, freq_vld, duty_vld, busy}, '0);
        chk("reset_ack", {freq_ack, duty_ack}, 2'b00);
        freq_req = 1'b0;
        @(negedge clk_50M);
        rst = 1'b1;
        #1;
        chk("post_reset_outputs", {freq_bcd, duty_bcd, freq_ovf, freq_vld, duty_vld, busy}, '0);
        chk("no_ack_without_req", {freq_ack, duty_ack}, 2'b00);

        // Simultaneous requests from reset: freq first, duty in the following IDLE.
        @(negedge clk_50M);
        freq_bin = 28'd1000;
        freq_req = 1'b1;
        duty_bin = 7'd50;
        duty_req = 1'b1;
        #1;
        chk("both_first_grant", {freq_ack, duty_ack}, 2'b10);
        @(posedge clk_50M);
        conv_tail(1'b0, 32'h00001000, 1'b0);
        #1;
        chk("duty_ack_after_freq", {freq_ack, duty_ack}, 2'b01);
        @(posedge clk_50M);
        conv_tail(1'b1, 32'h00000050, 1'b0);
        freq_bin = 28'd42;
        freq_req = 1'b1;
        duty_bin = 7'd7;
        duty_req = 1'b1;
        #1;
        chk("both_second_grant", {freq_ack, duty_ack}, 2'b01);
        @(posedge clk_50M);
        conv_tail(1'b1, 32'h00000007, 1'b0);
        #1;
        chk("freq_ack_after_duty", {freq_ack, duty_ack}, 2'b10);
        @(posedge clk_50M);
        conv_tail(1'b0, 32'h00000042, 1'b0);

        for (int i = 0; i < 8; i++) run(vecs[i].ch, vecs[i].val, vecs[i].bcd, vecs[i].ovf);

        for (int i = 0; i < 12; i++) begin
            ch = 1'($urandom_range(0, 1));
            if (ch) begin
                v = 28'($urandom_range(0, 127));
                m = {1'b0, 20'd0, to_bcd(64'(v))[11:0]};
            end else begin
                v = (i % 3 == 0) ? 28'(99999990 + $urandom_range(0, 20)) : 28'($urandom);
                m = model_freq(64'(v));
            end
            run(ch, v, m[31:0], m[32]);
        end

        // Reset in the middle of a frequency conversion discards it.
        run(1'b0, 28'd555, 32'h00000555, 1'b0);
        run(1'b1, 28'd99, 32'h00000099, 1'b0);
        start(1'b0, 28'd12345678);
        repeat (10) @(posedge clk_50M);
        #2;
        rst = 1'b0;
        freq_req = 1'b0;
        #1;
        chk("midconv_reset_outputs", {freq_bcd, duty_bcd, freq_ovf, freq_vld, duty_vld, busy}, '0);
        repeat (2) @(negedge clk_50M);
        rst = 1'b1;
        vld_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_50M);
            if (freq_vld || busy) vld_seen++;
        end
        chk("midconv_no_vld", 64'(vld_seen), 64'd0);
        run(1'b1, 28'd127, 32'h00000127, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Scheduler and arbiter that shares one iterative binary-to-BCD (shift-add-3) engine between two requesters on the oscilloscope display path.
  - Frequency counter: 28-bit value.
  - Duty-cycle measurement: 7-bit value.
- Replaces single-cycle unrolled conversion with one shift per clock.
- Arbitrates round-robin, handshakes operands in, and delivers registered BCD results with per-channel valid pulses to the display driver.

Parameters:
- FREQ_W, 28, frequency operand width (bits).
- FREQ_DIGITS, 8, BCD digits presented on freq_bcd.
- DUTY_W, 7, duty operand width (bits).
- DUTY_DIGITS, 3, BCD digits presented on duty_bcd.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- freq_req  in  1  frequency operand valid; held until acked.
- freq_bin  in  FREQ_W  frequency operand, binary.
- freq_ack  out  1  operand accepted this cycle.
- duty_req  in  1  duty operand valid; held until acked.
- duty_bin  in  DUTY_W  duty operand, binary.
- duty_ack  out  1  operand accepted this cycle.
- freq_bcd  out  4*FREQ_DIGITS  frequency result, BCD, MS digit at top.
- freq_vld  out  1  one-cycle pulse: freq_bcd updated.
- freq_ovf  out  1  overflow flag (see Optional Feature).
- duty_bcd  out  4*DUTY_DIGITS  duty result, BCD.
- duty_vld  out  1  one-cycle pulse: duty_bcd updated.
- busy  out  1  engine not idle.

Behaviour:
- Reset (rst low, async): FSM to IDLE; all outputs 0, including acks, busy, bcd outputs and ovf; round-robin pointer favours freq; internal shift register and counter cleared. Reset mid-conversion aborts it: no vld pulse, result discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Grant when any req is high. ack is combinational: state==IDLE and granted.
  - Transfer occurs on a req&&ack cycle T. The operand is latched at the end of T, and the BCD field and counter are cleared. Next state is SHIFT.
  - Only one req high: grant it.
  - Both high: grant the pointer's channel. The pointer then flips to the other channel.
- SHIFT: each cycle, first add 3 to every BCD nibble >=5 (all nibbles in parallel, same cycle), then shift the whole register left 1. Counter = W of the granted channel (28 or 7). After the last shift, go to DONE.
- DONE (one cycle): the granted channel's bcd/vld registers were loaded at the edge entering DONE. vld is high exactly during DONE, then the FSM returns to IDLE.
- busy = (state != IDLE).
- Latency: ack at T, vld at T+W+1.
  - freq: T+29. duty: T+8.
  - Occupancy W+2 cycles including IDLE.
- Internal BCD field is 9 digits for freq and 3 for duty.
- Outputs hold their last value between conversions. The other channel's outputs are untouched.
- Operand 0 converts normally to all-zero BCD with a vld pulse.
- req changes or drops during SHIFT/DONE: ignored; the latched operand is used. req still high in the IDLE after DONE is a new request.
- No ack is given outside IDLE.

Optional Feature:
- Macro BCD_SAT_EN.
- Defined: if the 9th freq digit is nonzero (freq_bin > 99,999,999), freq_bcd = 0x99999999 and freq_ovf = 1. Both update with freq_vld and hold until the next freq result. Otherwise freq_ovf = 0.
- Undefined: freq_bcd is the low 8 digits (value mod 10^8), and freq_ovf is tied 0.

Test Plan:
- Reset held, then released → all outputs 0, busy 0; no ack without req.
- freq_req with freq_bin=12,345,678 → freq_ack high 1 cycle at T, busy T+1..T+29, freq_vld at T+29 only, freq_bcd=0x12345678, duty outputs unchanged.
- duty_req with duty_bin=100 → duty_vld at T+8, duty_bcd=0x100. Then duty_bin=0 → duty_bcd=0x000 with vld.
- Both reqs high from reset:
  - freq (1,000) granted first, then duty (50) acked in the IDLE cycle after freq DONE.
  - Next simultaneous pair: duty granted first.
- freq_bin=268,435,455:
  - Without BCD_SAT_EN: 0x68435455, ovf 0.
  - With it: 0x99999999, ovf 1.
  - freq_bin=99,999,999 → 0x99999999, ovf 0.
- rst pulsed low at shift 10 of a freq conversion → outputs 0, no freq_vld. Then duty_bin=127 converts to 0x127.
